// File: rtl/mxpl_pkg.sv
// Shared widths and FSM state type for the max-pool feeder and the pooling subunit.
package mxpl_pkg;
  localparam int DATAW  = 20;
  localparam int ADDRW  = 12;
  localparam int IMG_W  = 64;
  localparam int OUT_AW = 10;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    WAIT,
    WRITE,
    FIN
  } state_t;
endpackage

// File: rtl/mxpl_addr_gen.sv
// Maps a pooled-window index and a 2x2 element index onto a conv-buffer address.
module mxpl_addr_gen #(
  parameter int ADDRW  = mxpl_pkg::ADDRW,
  parameter int IMG_W  = mxpl_pkg::IMG_W,
  parameter int OUT_AW = mxpl_pkg::OUT_AW
) (
  input  logic [OUT_AW-1:0] i_w,
  input  logic [1:0]        i_elem,
  output logic [ADDRW-1:0]  o_mem_addr
);
  localparam int PC_W = OUT_AW / 2;

  logic [ADDRW-1:0] w_base;
  logic [ADDRW-1:0] w_off;

  // Top-left pixel of the window: row 2*pr, column 2*pc.
  assign w_base     = ADDRW'({i_w[OUT_AW-1:PC_W], 1'b0, i_w[PC_W-1:0], 1'b0});
  assign w_off      = (i_elem[1] ? ADDRW'(IMG_W) : '0) + ADDRW'(i_elem[0]);
  assign o_mem_addr = w_base + w_off;
endmodule

// File: rtl/mxpl_feed.sv
// Walks a 64x64 conv map in 2x2 windows, streams each window to the pooling
// subunit and writes the returned maximum into the 32x32 pooled buffer.
module mxpl_feed #(
  parameter int DATAW  = mxpl_pkg::DATAW,
  parameter int ADDRW  = mxpl_pkg::ADDRW,
  parameter int IMG_W  = mxpl_pkg::IMG_W,
  parameter int OUT_AW = mxpl_pkg::OUT_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [ADDRW-1:0]  mem_addr,
  input  logic [DATAW-1:0]  mem_data,
  output logic [DATAW-1:0]  data,
  output logic              convDone,
  input  logic              mxplDone,
  input  logic [DATAW-1:0]  result,
  output logic              wr_en,
  output logic [OUT_AW-1:0] wr_addr,
  output logic [DATAW-1:0]  wr_data
);
  import mxpl_pkg::*;

  state_t            r_state;
  state_t            w_state_next;
  logic [OUT_AW-1:0] r_w;
  logic [1:0]        r_elem;
  logic              r_rd_d1;
  logic              r_conv_done;
  logic [DATAW-1:0]  r_data;
  logic [OUT_AW-1:0] r_wr_addr;
  logic [DATAW-1:0]  r_wr_data;

  logic              w_mem_rd;
  logic              w_wr_en;
  logic              w_done;
  logic              w_busy;
  logic              w_last_win;
  logic [ADDRW-1:0]  w_rd_addr;

  assign w_last_win = &r_w;

  mxpl_addr_gen #(
    .ADDRW  (ADDRW),
    .IMG_W  (IMG_W),
    .OUT_AW (OUT_AW)
  ) u_addr_gen (
    .i_w        (r_w),
    .i_elem     (r_elem),
    .o_mem_addr (w_rd_addr)
  );

  always_comb begin
    w_state_next = r_state;
    w_mem_rd     = 1'b0;
    w_wr_en      = 1'b0;
    w_done       = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (start) w_state_next = READ;
      end
      READ: begin
        w_mem_rd = 1'b1;
        if (r_elem == 2'd3) w_state_next = DRAIN;
      end
      // Leave once the last operand is on data: convDone high, nothing left in flight.
      DRAIN: begin
        if (r_conv_done && !r_rd_d1) w_state_next = WAIT;
      end
      WAIT: begin
        if (mxplDone) w_state_next = WRITE;
      end
      WRITE: begin
        w_wr_en      = 1'b1;
        w_state_next = w_last_win ? FIN : READ;
      end
      FIN: begin
        w_done       = 1'b1;
        w_busy       = 1'b0;
        w_state_next = IDLE;
      end
      default: begin
        w_busy       = 1'b0;
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_w         <= '0;
      r_elem      <= '0;
      r_rd_d1     <= 1'b0;
      r_conv_done <= 1'b0;
      r_data      <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_state     <= w_state_next;
      // Read data arrives one cycle after mem_rd and is registered one cycle later.
      r_rd_d1     <= w_mem_rd;
      r_conv_done <= r_rd_d1;
      if (r_rd_d1) r_data <= mem_data;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_w    <= '0;
            r_elem <= '0;
          end
        end
        READ: r_elem <= r_elem + 2'd1;
        WAIT: begin
          if (mxplDone) begin
            r_wr_data <= result;
            r_wr_addr <= r_w;
          end
        end
        WRITE: begin
          if (!w_last_win) r_w <= r_w + OUT_AW'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy     = w_busy;
  assign done     = w_done;
  assign mem_rd   = w_mem_rd;
  assign mem_addr = w_mem_rd ? w_rd_addr : '0;
  assign data     = r_data;
  assign convDone = r_conv_done;
  assign wr_en    = w_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
endmodule

// File: tb/tb_mxpl_feed.sv
// Bench for mxpl_feed: conv-buffer and pooling-subunit models plus a window-level
// reference that predicts every read address, operand and pooled write.
module tb_mxpl_feed;
  localparam int DW = 20;
  localparam int AW = 12;
  localparam int OW = 10;
  localparam int NW = 1024;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, mem_rd, convDone, wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data = '0;
  logic [DW-1:0] data, wr_data;
  logic          mxplDone = 1'b0;
  logic [DW-1:0] result = '0;
  logic [OW-1:0] wr_addr;

  always #5 clk = ~clk;

  mxpl_feed dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .data     (data),
    .convDone (convDone),
    .mxplDone (mxplDone),
    .result   (result),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  int tot = 0;
  int bad = 0;

  logic [DW-1:0] mem [0:4095];

  // reference-model state
  bit            mb = 1'b0;
  bit            exp_done = 1'b0;
  bit            cur_mb, cur_done, nd;
  int            rd_n = 0, cd_n = 0, wr_cnt = 0, done_cnt = 0, given = 0;
  int            pool_wait = 0, stall_w = -1, stall_act = 0;
  logic [DW-1:0] pool_res = '0;
  logic [DW-1:0] last_data = '0;
  bit            spur_en = 1'b0;
  bit            pend = 1'b0;
  logic [AW-1:0] pend_addr = '0;
  logic [1:0]    rd_hist = '0;
  logic [AW-1:0] rd_log [NW][4];
  logic [DW-1:0] cd_log [NW][4];
  logic [DW-1:0] wr_log [NW];
  int            wr_hits [NW];

  typedef struct {
    int                  w;
    logic [3:0][AW-1:0]  a;
    logic [3:0][DW-1:0]  v;
    logic [DW-1:0]       mx;
  } vec_t;
  vec_t tbl [6];

  function automatic vec_t mk(int w, int a0, int a1, int a2, int a3,
                              int v0, int v1, int v2, int v3, int mx);
    vec_t r;
    r.w  = w;
    r.a  = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    r.v  = {DW'(v3), DW'(v2), DW'(v1), DW'(v0)};
    r.mx = DW'(mx);
    return r;
  endfunction

  // Window w covers pooled row w/32, column w%32; elements in raster order.
  function automatic logic [AW-1:0] addr_of(int w, int e);
    int pr = w / 32;
    int pc = w % 32;
    return AW'(pr * 2 * 64 + pc * 2 + (e % 2) + (e / 2) * 64);
  endfunction

  function automatic logic [DW-1:0] win_max(int w);
    logic signed [DW-1:0] m, v;
    m = mem[addr_of(w, 0)];
    for (int e = 1; e < 4; e++) begin
      v = mem[addr_of(w, e)];
      if (v > m) m = v;
    end
    return m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor, memory responder and pooling-subunit model, all on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_mem_rd", mem_rd, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_data", data, 0);
      chk("rst_convDone", convDone, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      mb = 1'b0; exp_done = 1'b0; pend = 1'b0; rd_hist = '0;
      pool_wait = 0; mxplDone = 1'b0; mem_data = '0; last_data = '0;
    end else begin
      cur_mb = mb; cur_done = exp_done; nd = 1'b0;
      chk("busy", busy, cur_mb);
      chk("done", done, cur_done);
      if (done) done_cnt++;

      mem_data = pend ? mem[pend_addr] : DW'($urandom);
      pend = mem_rd; pend_addr = mem_addr;

      mxplDone = 1'b0;
      if (pool_wait > 0) begin
        pool_wait--;
        if (pool_wait == 0) begin
          mxplDone = 1'b1; result = pool_res; given++;
        end
      end else if (spur_en && mem_rd && $urandom_range(0, 3) == 0) begin
        mxplDone = 1'b1; result = DW'($urandom);
      end
      if (pool_wait > 0 && (mem_rd || convDone)) stall_act++;

      if (mem_rd) begin
        chk("rd_in_pass", cur_mb, 1);
        chk("rd_after_prev_write", (rd_n / 4) <= wr_cnt, 1);
        if (rd_n < 4 * NW) begin
          chk("rd_addr", mem_addr, addr_of(rd_n / 4, rd_n % 4));
          rd_log[rd_n / 4][rd_n % 4] = mem_addr;
        end
        rd_n++;
      end

      if (convDone || rd_hist[1]) chk("cd_timing", convDone, rd_hist[1]);
      if (convDone) begin
        chk("cd_window", cd_n / 4, wr_cnt);
        if (cd_n < 4 * NW) begin
          chk("cd_data", data, mem[addr_of(cd_n / 4, cd_n % 4)]);
          cd_log[cd_n / 4][cd_n % 4] = data;
        end
        if (cd_n % 4 == 0 || $signed(data) > $signed(pool_res)) pool_res = data;
        last_data = data;
        cd_n++;
        if (cd_n % 4 == 0)
          pool_wait = 1 + ((cd_n / 4 - 1 == stall_w) ? 50 : int'($urandom_range(0, 3)));
      end else begin
        chk("data_hold", data, last_data);
      end
      rd_hist = {rd_hist[0], mem_rd};

      if (wr_en) begin
        chk("wr_after_mxplDone", given > wr_cnt, 1);
        chk("wr_addr", wr_addr, wr_cnt);
        chk("wr_data", wr_data, win_max(wr_cnt));
        wr_log[wr_addr] = wr_data;
        wr_hits[wr_addr]++;
        wr_cnt++;
        if (wr_cnt == NW) begin
          mb = 1'b0; nd = 1'b1;
        end
      end

      if (start && !cur_mb && !cur_done) begin
        mb = 1'b1; rd_n = 0; cd_n = 0; wr_cnt = 0; given = 0; pool_wait = 0;
        for (int i = 0; i < NW; i++) wr_hits[i] = 0;
      end
      exp_done = nd;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_writes(input int n, input int budget, input string nm);
    int c = 0;
    while (wr_cnt < n && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    chk(nm, wr_cnt >= n, 1);
  endtask

  task automatic check_hits(input string nm);
    int nbad = 0;
    for (int i = 0; i < NW; i++) if (wr_hits[i] != 1) nbad++;
    chk(nm, nbad, 0);
  endtask

  initial begin
    int dc, wc, c;
    #1 reset = 1'b0;
    for (int a = 0; a < 4096; a++) mem[a] = DW'($urandom);
    tbl[0] = mk(0,    0,    1,    64,   65,   0, 1, 64, 65, 65);
    tbl[1] = mk(1,    2,    3,    66,   67,   -5, -3, -8, -4, 'hFFFFD);
    tbl[2] = mk(32,   128,  129,  192,  193,  10, 40, 30, 20, 40);
    tbl[3] = mk(33,   130,  131,  194,  195,  7, -1, 'h7FFFF, 'h80000, 'h7FFFF);
    tbl[4] = mk(1023, 4030, 4031, 4094, 4095, 'h80000, 'h80001, 'h80002, 'h80000, 'h80002);
    tbl[5] = mk(31,   62,   63,   126,  127,  3, 3, 3, 3, 3);
    foreach (tbl[i]) for (int e = 0; e < 4; e++) mem[tbl[i].a[e]] = tbl[i].v[e];

    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);

    // Pass 1: full pass with spurious strobes and one 50-cycle stall at window 5.
    spur_en = 1'b1; stall_w = 5;
    pulse_start();
    wait_writes(NW, 15000, "p1_complete");
    repeat (3) @(negedge clk);
    #1;
    chk("p1_writes", wr_cnt, NW);
    chk("p1_done_count", done_cnt, 1);
    chk("p1_stall_quiet", stall_act, 0);
    check_hits("p1_one_write_per_window");
    foreach (tbl[i]) begin
      for (int e = 0; e < 4; e++) begin
        chk("vec_rd_addr", rd_log[tbl[i].w][e], tbl[i].a[e]);
        chk("vec_operand", cd_log[tbl[i].w][e], tbl[i].v[e]);
      end
      chk("vec_wr_data", wr_log[tbl[i].w], tbl[i].mx);
      $display("vec %0d: window %0d pooled 0x%05h", i, tbl[i].w, wr_log[tbl[i].w]);
    end

    // Pass 2: reset in the middle of window 300's reads aborts the pass.
    stall_w = -1;
    pulse_start();
    c = 0;
    while (rd_n <= 300 * 4 && c < 5000) begin
      @(negedge clk); #1;
      c++;
    end
    chk("p2_reach_w300", rd_n > 300 * 4, 1);
    dc = done_cnt; wc = wr_cnt;
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    chk("p2_writes_before_abort", wc, 300);
    chk("p2_no_write_after", wr_cnt, wc);
    chk("p2_no_done", done_cnt, dc);
    chk("p2_idle_after_reset", busy, 0);
    $display("pass 2: aborted after %0d writes", wc);

    // Pass 3: start pulsed while busy is ignored; start in FIN ignored, next IDLE accepted.
    pulse_start();
    wait_writes(500, 8000, "p3_reach_500");
    pulse_start();
    wait_writes(NW, 15000, "p3_complete");
    check_hits("p3_one_write_per_window");
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 start = 1'b0;
    chk("p3_done_count", done_cnt, 2);
    chk("p4_busy_after_idle_start", busy, 1);
    wait_writes(2, 100, "p4_restart_writes");
    $display("pass 3: restart accepted, %0d windows written", wr_cnt);
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
